if_queue: RTL
=============

IF_QUEUE -- requirements
Module: if_queue

Interface
REQ-001 Parameter DEPTH, default 4, instruction queue entries; power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-003 clk  in  1  system clock; all state updates on posedge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 rdy  in  1  global ready; low freezes all state (except rst).
REQ-006 mem_req  out  1  fetch request to memory, held until accepted.
REQ-007 mem_pc  out  32  fetch address, stable while mem_req high.
REQ-008 mem_gnt  in  1  memory response valid; one per request.
REQ-009 mem_ins  in  32  instruction word, valid with mem_gnt.
REQ-010 redirect  in  1  flush request from core (mispredict or JALR).
REQ-011 redirect_pc  in  32  new fetch address, valid with redirect.
REQ-012 stall  in  1  core cannot accept an instruction this cycle.
REQ-013 out_valid  out  1  queue head valid.
REQ-014 out_pc  out  32  PC of head instruction.
REQ-015 out_ins  out  32  raw head instruction.
REQ-016 out_pred_pc  out  32  predicted next PC of head.
REQ-017 count  out  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-018 Fetch FSM SHALL have states IDLE, WAIT, DROP.
REQ-019 IDLE: if count < DEPTH and no redirect, SHALL assert mem_req with mem_pc = fetch PC and enter WAIT next cycle.
REQ-020 WAIT: mem_req SHALL stay high; on mem_gnt push {fetch PC, mem_ins, predicted PC}, update fetch PC, return to IDLE.
REQ-021 Prediction: opcode 1101111 (JAL) predicts PC + sign-extended J-immediate; opcode 1100011 (branch) and all others predict PC + 4; arithmetic is modulo 2^32.
REQ-022 Fetch PC SHALL advance to the predicted PC of the pushed instruction.
REQ-023 Issue reserves space: a request is issued only when count < DEPTH, so a push never finds the queue full.
REQ-024 Pop occurs when out_valid && !stall && rdy; head advances one entry, pointers wrap modulo DEPTH.
REQ-025 Simultaneous push and pop SHALL leave count unchanged.
REQ-026 out_valid = (count != 0); out_pc, out_ins and out_pred_pc SHALL read the head entry combinationally.
REQ-027 Redirect SHALL have priority over push and pop: queue emptied (count = 0), fetch PC = redirect_pc, effective next cycle.
REQ-028 Redirect in WAIT without mem_gnt SHALL go to DROP; DROP discards the next mem_gnt, then goes to IDLE.
REQ-029 Redirect coincident with mem_gnt in WAIT SHALL discard that response and go to IDLE.
REQ-030 Redirect in DROP SHALL update fetch PC again and remain in DROP.
REQ-031 mem_req SHALL be low in DROP and while rdy is low.
REQ-032 Latency: a granted instruction becomes visible on out_valid the cycle after mem_gnt.

Reset
REQ-033 On rst: state IDLE, fetch PC = RESET_PC, pointers and count = 0, mem_req = 0, out_valid = 0; queue storage is not cleared.
REQ-034 Reset asserted mid-request SHALL drop the outstanding request; a late mem_gnt after reset is ignored in IDLE.

Structure
REQ-035 Opcode constants (JAL, BRANCH) and FSM state encodings SHALL live in the shared def.v.
REQ-036 One combinational sub-module, pred_decode (ins, pc -> pred_pc), SHALL be instantiated.

Verification
REQ-037 Reset, memory returns ADDI at 0,4,8 with 1-cycle grant, stall low -> out_pc sequence 0,4,8, out_pred_pc 4,8,12.
REQ-038 JAL +16 at PC 0x20 -> next mem_pc 0x30, entry out_pred_pc = 0x30.
REQ-039 DEPTH=4, stall high, continuous grants -> count reaches 4, mem_req stays low; release stall -> one pop per cycle, fetching resumes.
REQ-040 redirect to 0x100 while in WAIT, grant 2 cycles later -> response dropped, count 0, next mem_pc 0x100.
REQ-041 redirect in same cycle as mem_gnt and pop -> queue empty next cycle, no push, mem_pc = redirect_pc.
REQ-042 rdy low for 3 cycles with queue at 2 entries -> count, pointers, fetch PC unchanged; mem_req low.

Source files
------------

// File: rtl/if_queue_pkg.sv
// Shared definitions for the instruction fetch queue: opcodes, FSM encoding
// and the J-type immediate extractor used by the next-PC predictor.
package if_queue_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  function automatic logic signed [31:0] j_imm(input logic [31:0] ins);
    return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/if_queue_pred_decode.sv
// Static next-PC predictor: JAL jumps to its target, everything else
// (branches included) falls through to PC + 4.
module if_queue_pred_decode
  import if_queue_pkg::*;
(
  input  logic [31:0] ins,
  input  logic [31:0] pc,
  output logic [31:0] pred_pc
);

  always_comb begin
    pred_pc = pc + 32'd4;
    case (ins[6:0])
      OPC_JAL:    pred_pc = pc + j_imm(ins);
      OPC_BRANCH: pred_pc = pc + 32'd4;
      default:    pred_pc = pc + 32'd4;
    endcase
  end

endmodule

// File: rtl/if_queue.sv
// Instruction fetch unit with a small circular queue: issues one memory
// request at a time, predicts the next PC and flushes on core redirect.
module if_queue
  import if_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  output logic                     mem_req,
  output logic [31:0]              mem_pc,
  input  logic                     mem_gnt,
  input  logic [31:0]              mem_ins,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     stall,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_ins,
  output logic [31:0]              out_pred_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_state_t     state, state_nxt;
  logic [31:0]      fetch_pc;
  logic [31:0]      pred_pc;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             push, pop, has_space;

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] ins_mem  [DEPTH];
  logic [31:0] pred_mem [DEPTH];

  if_queue_pred_decode pred_decode (
    .ins     (mem_ins),
    .pc      (fetch_pc),
    .pred_pc (pred_pc)
  );

  // Space is checked at issue time; only one request is ever in flight,
  // so a grant can always be pushed.
  assign has_space = (cnt < CNT_W'(DEPTH));
  assign pop       = rdy && out_valid && !stall && !redirect;

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    push      = 1'b0;
    if (rdy && !rst) begin
      unique case (state)
        IDLE: begin
          if (has_space && !redirect) begin
            mem_req   = 1'b1;
            state_nxt = WAIT;
          end
        end
        WAIT: begin
          mem_req = 1'b1;
          if (redirect) begin
            state_nxt = mem_gnt ? IDLE : DROP;
          end else if (mem_gnt) begin
            push      = 1'b1;
            state_nxt = IDLE;
          end
        end
        // A grant arriving together with a new redirect still retires the
        // stale request, so leave DROP rather than wait for a second grant.
        DROP: begin
          if (mem_gnt) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
    end else if (rdy) begin
      state <= state_nxt;
      if (redirect) begin
        fetch_pc <= redirect_pc;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        cnt      <= '0;
      end else begin
        if (push) begin
          fetch_pc <= pred_pc;
          wr_ptr   <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   cnt <= cnt + CNT_W'(1);
          2'b01:   cnt <= cnt - CNT_W'(1);
          default: cnt <= cnt;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      ins_mem[wr_ptr]  <= mem_ins;
      pred_mem[wr_ptr] <= pred_pc;
    end
  end

  assign mem_pc      = fetch_pc;
  assign out_valid   = (cnt != '0);
  assign out_pc      = pc_mem[rd_ptr];
  assign out_ins     = ins_mem[rd_ptr];
  assign out_pred_pc = pred_mem[rd_ptr];
  assign count       = cnt;

endmodule
